// File: rtl/count_display_pkg.sv
// rtl/count_display_pkg.sv - shared FSM states, digit index encoding and 7-seg codes
package count_display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_LATCH   = 2'd2
   } fsm_state_e;

   typedef enum logic [1:0] {
      DIG_UNITS    = 2'd0,
      DIG_TENS     = 2'd1,
      DIG_HUNDREDS = 2'd2
   } dig_idx_e;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

   // Double-dabble correction applied to each nibble before the shift.
   function automatic logic [3:0] add3_ge5(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// rtl/bcd_seg_decoder.sv - combinational BCD digit to 7-segment decoder with blanking
module bcd_seg_decoder
   import count_display_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   assign seg = blank ? SEG_BLANK : seg_code(bcd);

endmodule

// File: rtl/count_bcd_display.sv
// rtl/count_bcd_display.sv - binary-to-BCD converter driving a 3-digit muxed 7-seg display (option: LEADING_ZERO_BLANK_EN)
module count_bcd_display
   import count_display_pkg::*;
#(
   parameter int REFRESH_DIV = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_count,
   output logic       in_ready,
   output logic [6:0] seg,
   output logic [2:0] dig_en,
   output logic       busy
);

   localparam int RW = $clog2(REFRESH_DIV);

   fsm_state_e    state_q, state_d;
   logic [7:0]    bin_q, bin_d;
   logic [11:0]   bcd_q, bcd_d;
   logic [2:0]    shift_cnt_q, shift_cnt_d;
   logic [11:0]   digits_q, digits_d;
   logic [RW-1:0] refresh_q, refresh_d;
   dig_idx_e      idx_q, idx_d;
   logic [2:0]    dig_en_q, dig_en_d;
   logic [6:0]    seg_q, seg_d;

   logic [11:0]   bcd_adj;
   logic [19:0]   shifted;
   logic [3:0]    sel_digit;
   logic          blank;

   assign bcd_adj = {add3_ge5(bcd_q[11:8]), add3_ge5(bcd_q[7:4]), add3_ge5(bcd_q[3:0])};
   assign shifted = {bcd_adj, bin_q} << 1;

   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      shift_cnt_d = shift_cnt_q;
      digits_d    = digits_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d     = ST_CONVERT;
               bin_d       = in_count;
               bcd_d       = '0;
               shift_cnt_d = '0;
            end
         end
         ST_CONVERT: begin
            bcd_d       = shifted[19:8];
            bin_d       = shifted[7:0];
            shift_cnt_d = shift_cnt_q + 3'd1;
            if (shift_cnt_q == 3'd7) state_d = ST_LATCH;
         end
         ST_LATCH: begin
            digits_d = bcd_q;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign in_ready = (state_q == ST_IDLE);
   assign busy     = (state_q != ST_IDLE);

   // Refresh mux runs freely; seg is decoded from next-cycle index and digits so it moves with dig_en.
   always_comb begin
      refresh_d = refresh_q + RW'(1);
      idx_d     = idx_q;
      if (refresh_q == RW'(REFRESH_DIV - 1)) begin
         refresh_d = '0;
         case (idx_q)
            DIG_UNITS: idx_d = DIG_TENS;
            DIG_TENS:  idx_d = DIG_HUNDREDS;
            default:   idx_d = DIG_UNITS;
         endcase
      end
      case (idx_d)
         DIG_TENS:     begin sel_digit = digits_d[7:4];  dig_en_d = 3'b010; end
         DIG_HUNDREDS: begin sel_digit = digits_d[11:8]; dig_en_d = 3'b100; end
         default:      begin sel_digit = digits_d[3:0];  dig_en_d = 3'b001; end
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      blank = ((idx_d == DIG_HUNDREDS) && (digits_d[11:8] == 4'd0)) ||
              ((idx_d == DIG_TENS) && (digits_d[11:8] == 4'd0) && (digits_d[7:4] == 4'd0));
`else
      blank = 1'b0;
`endif
   end

   bcd_seg_decoder u_dec (
      .bcd   (sel_digit),
      .blank (blank),
      .seg   (seg_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bin_q       <= '0;
         bcd_q       <= '0;
         shift_cnt_q <= '0;
         digits_q    <= '0;
         refresh_q   <= '0;
         idx_q       <= DIG_UNITS;
         dig_en_q    <= 3'b001;
         seg_q       <= SEG_0;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         shift_cnt_q <= shift_cnt_d;
         digits_q    <= digits_d;
         refresh_q   <= refresh_d;
         idx_q       <= idx_d;
         dig_en_q    <= dig_en_d;
         seg_q       <= seg_d;
      end
   end

   assign seg    = seg_q;
   assign dig_en = dig_en_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// tb/tb_count_bcd_display.sv - scoreboard bench for count_bcd_display (honours LEADING_ZERO_BLANK_EN)
module tb_count_bcd_display;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_count = 8'd0;
   logic       in_ready;
   logic [6:0] seg;
   logic [2:0] dig_en;
   logic       busy;

   count_bcd_display #(.REFRESH_DIV(DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_count (in_count),
      .in_ready (in_ready),
      .seg      (seg),
      .dig_en   (dig_en),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int val;
      int acc;
      int done;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   rst_base = 0;
   int   model_val = 0;
   int   checks = 0;
   int   errors = 0;
   bit   busy_prev = 1'b0;
   logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   function automatic bit model_idle();
      return (q.size() == 0) || (cyc >= q[$].done);
   endfunction

   function automatic int exp_seg(input int val, input int idx);
      int d [3];
      d[0] = val % 10;
      d[1] = (val / 10) % 10;
      d[2] = val / 100;
`ifdef LEADING_ZERO_BLANK_EN
      if (idx == 2 && d[2] == 0) return 0;
      if (idx == 1 && d[2] == 0 && d[1] == 0) return 0;
`endif
      return int'(codes[d[idx]]);
   endfunction

   // Monitor: pops the scoreboard when the DUT finishes a conversion, checks display every cycle.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            busy_prev = 1'b0;
         end else begin
            int  idx;
            bit  exp_ready;
            if (busy_prev && !busy) begin
               if (q.size() == 0) begin
                  chk("pop_unexpected", 1, 0);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  chk("latency", cyc, e.done);
                  model_val = e.val;
               end
            end
            busy_prev = busy;
            exp_ready = (q.size() == 0) || (cyc >= q[$].done) || (cyc == q[$].acc);
            chk("in_ready", int'(in_ready), int'(exp_ready));
            chk("busy", int'(busy), int'(!exp_ready));
            idx = ((cyc - rst_base) / DIV) % 3;
            chk("dig_en", int'(dig_en), 1 << idx);
            chk("seg", int'(seg), exp_seg(model_val, idx));
         end
      end
   end

   task automatic step(input bit v, input logic [7:0] c, output bit took);
      @(negedge clk);
      in_valid = v;
      in_count = c;
      took = v && model_idle();
      if (took) q.push_back('{int'(c), cyc, cyc + 10});
   endtask

   task automatic accept(input int val);
      bit took = 1'b0;
      for (int i = 0; i < 30 && !took; i++) step(1'b1, val[7:0], took);
      if (!took) chk("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      bit t;
      for (int i = 0; i < 30 && !model_idle(); i++) step(1'b0, 8'd0, t);
      step(1'b0, 8'd0, t);
      step(1'b0, 8'd0, t);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      model_val = 0;
      rst_base = cyc;
   endtask

   initial begin
      bit t;
      do_reset();
      for (int i = 0; i < 3 * DIV + 2; i++) step(1'b0, 8'd0, t);

      accept(255);
      drain();
      accept(100);
      drain();
      for (int i = 0; i < 2 * DIV; i++) step(1'b0, 8'd0, t);
      accept(7);
      drain();
      for (int i = 0; i < 2 * DIV; i++) step(1'b0, 8'd0, t);

      accept(42);
      for (int i = 0; i < 8; i++) step(1'b1, 8'd99, t);
      drain();
      for (int i = 0; i < 3 * DIV; i++) step(1'b0, 8'd0, t);

      accept(123);
      drain();
      accept(200);
      for (int i = 0; i < 4; i++) step(1'b0, 8'd0, t);
      do_reset();
      for (int i = 0; i < DIV + 1; i++) step(1'b0, 8'd0, t);

      for (int n = 0; n < 40; n++) begin
         int gap;
         accept(int'($urandom_range(0, 255)));
         gap = int'($urandom_range(0, 14));
         for (int i = 0; i < gap; i++) step(1'($urandom), 8'($urandom), t);
      end
      drain();

      for (int v = 0; v < 256; v++) accept(v);
      drain();

      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

endmodule

// File: doc/count_bcd_display.md
COUNT_BCD_DISPLAY -- requirements
Module: count_bcd_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 1000, clk cycles each digit stays enabled before the mux advances (legal >= 2).
REQ-002 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, upstream counter value valid.
REQ-005 SHALL have port in_count, input, 8, unsigned binary count from the upstream counter.
REQ-006 SHALL have port in_ready, output, 1, block can accept a new value.
REQ-007 SHALL have port seg, output, 7, segment drive, active-high, bit0=a .. bit6=g.
REQ-008 SHALL have port dig_en, output, 3, one-hot digit enable; bit0=units, bit1=tens, bit2=hundreds.
REQ-009 SHALL have port busy, output, 1, conversion in progress.

Function
REQ-010 SHALL implement FSM states IDLE, CONVERT, LATCH; IDLE->CONVERT on in_valid&&in_ready; CONVERT->LATCH after 8th shift; LATCH->IDLE unconditionally.
REQ-011 SHALL drive in_ready=1 only in IDLE and busy=1 in CONVERT and LATCH.
REQ-012 SHALL capture in_count on the accept edge; in_valid/in_count outside IDLE SHALL be ignored (no queuing).
REQ-013 SHALL convert by shift-add-3 (double-dabble), one bit per cycle MSB first, 12-bit BCD scratch, add 3 to any nibble >= 5 before each shift.
REQ-014 SHALL update displayed digit registers in LATCH only; accept at edge N -> new digits visible after edge N+9; in_ready high again after edge N+9.
REQ-015 SHALL hold previous displayed digits unchanged throughout CONVERT.
REQ-016 SHALL run a refresh counter 0..REFRESH_DIV-1 independent of FSM; on wrap advance digit index units->tens->hundreds->units.
REQ-017 SHALL drive seg from the currently indexed digit via the 7-seg code: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex).
REQ-018 SHALL register seg and dig_en so both change on the same edge as the digit index.
REQ-019 SHALL produce all values 0..255 exactly; hundreds digit never exceeds 2.

Reset
REQ-020 SHALL on rst: FSM=IDLE, in_ready=1, busy=0, digits=0,0,0, refresh counter=0, digit index=units, dig_en=001, seg=3F.
REQ-021 SHALL, on rst asserted mid-CONVERT or LATCH, abandon the conversion with no digit update; rst has priority over in_valid.

Configuration
REQ-022 SHALL support macro LEADING_ZERO_BLANK_EN.
REQ-023 With LEADING_ZERO_BLANK_EN defined: hundreds seg=00 when hundreds=0; tens seg=00 when hundreds=0 and tens=0; units never blanked; dig_en unaffected.
REQ-024 Without LEADING_ZERO_BLANK_EN: all three digits always show their code, including leading zeros.

Structure
REQ-025 SHALL place FSM state enum, digit-index encoding and the 7-seg code constants in shared package count_display_pkg.
REQ-026 SHALL use one sub-module, bcd_seg_decoder (4-bit BCD + blank -> 7-bit seg, combinational); conversion FSM and refresh mux stay in the top.

Verification
REQ-027 Accept in_count=255 -> after 9 cycles digits 2,5,5; units seg=6D, tens seg=6D, hundreds seg=5B.
REQ-028 Accept 100 with LEADING_ZERO_BLANK_EN -> hundreds=06, tens=3F (not blanked), units=3F; accept 7 -> hundreds=00, tens=00, units=07.
REQ-029 Accept 42, then in_valid=1 with 99 for cycles 1..8 -> in_ready=0, 99 ignored, display 0,4,2; in_ready=1 at cycle 9.
REQ-030 REFRESH_DIV=4 -> dig_en sequence 001,010,100,001 with each held exactly 4 cycles.
REQ-031 Display 123, accept 200, assert rst at cycle 4 of CONVERT -> next edge digits 0,0,0, dig_en=001, seg=3F, in_ready=1.
REQ-032 Exhaustive sweep 0..255 back-to-back -> every latched digit triple equals decimal value, reference model compare.
